// File: rtl/video_pkg.sv
// video_pkg: shared video constants, colour type, direction type and palette
package video_pkg;
    localparam int COORD_BITS  = 10;
    localparam int COLOUR_BITS = 8;
    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    typedef struct packed {
        logic [COLOUR_BITS-1:0] r;
        logic [COLOUR_BITS-1:0] g;
        logic [COLOUR_BITS-1:0] b;
    } rgb_t;
    typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;
    localparam rgb_t BG_COLOUR = 24'h00008B;
    localparam rgb_t PALETTE [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'hFFFF00};
endpackage

// File: rtl/square_motion.sv
// square_motion: per-frame square position/direction update with edge bounce and palette step
module square_motion #(
    parameter int COORD_BITS = video_pkg::COORD_BITS,
    parameter int H_RES      = video_pkg::H_RES,
    parameter int V_RES      = video_pkg::V_RES,
    parameter int SQ_SIZE    = 64,
    parameter int SPEED      = 2,
    parameter int X0         = 0,
    parameter int Y0         = 0
) (
    input  logic                  i_clk_pxl,
    input  logic                  i_reset,
    input  logic                  i_nf,
    input  logic                  i_pause,
    output logic [COORD_BITS-1:0] o_pos_x,
    output logic [COORD_BITS-1:0] o_pos_y,
    output logic [1:0]            o_idx,
    output logic                  o_corner
);
    import video_pkg::*;
    localparam int W = COORD_BITS + 1;
    typedef struct packed {
        logic [COORD_BITS-1:0] pos;
        dir_t                  dir;
        logic                  bounce;
    } axis_t;
    // One extra bit keeps pos+SQ_SIZE+SPEED from wrapping near the far edge
    function automatic axis_t step(input logic [COORD_BITS-1:0] pos, input dir_t dir, input logic [W-1:0] lim);
        logic [W-1:0] p;
        p = {1'b0, pos};
        if (dir == DIR_POS)
            return (p + W'(SQ_SIZE + SPEED) >= lim)
                ? axis_t'{pos: COORD_BITS'(lim - W'(SQ_SIZE)), dir: DIR_NEG, bounce: 1'b1}
                : axis_t'{pos: COORD_BITS'(p + W'(SPEED)), dir: DIR_POS, bounce: 1'b0};
        return (p <= W'(SPEED))
            ? axis_t'{pos: '0, dir: DIR_POS, bounce: 1'b1}
            : axis_t'{pos: COORD_BITS'(p - W'(SPEED)), dir: DIR_NEG, bounce: 1'b0};
    endfunction
    logic [COORD_BITS-1:0] r_pos_x, r_pos_y;
    dir_t                  r_dir_x, r_dir_y;
    logic [1:0]            r_idx;
    logic                  r_corner;
    axis_t                 w_x, w_y;
    logic                  w_go;
    always_comb begin
        w_go = i_nf && !i_pause;
        w_x  = step(r_pos_x, r_dir_x, W'(H_RES));
        w_y  = step(r_pos_y, r_dir_y, W'(V_RES));
    end
    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            r_pos_x  <= COORD_BITS'(X0);
            r_pos_y  <= COORD_BITS'(Y0);
            r_dir_x  <= DIR_POS;
            r_dir_y  <= DIR_POS;
            r_idx    <= '0;
            r_corner <= 1'b0;
        end else begin
            r_corner <= w_go && w_x.bounce && w_y.bounce;
            if (w_go) begin
                r_pos_x <= w_x.pos;
                r_pos_y <= w_y.pos;
                r_dir_x <= w_x.dir;
                r_dir_y <= w_y.dir;
                r_idx   <= r_idx + {1'b0, w_x.bounce | w_y.bounce};
            end
        end
    end
    assign o_pos_x  = r_pos_x;
    assign o_pos_y  = r_pos_y;
    assign o_idx    = r_idx;
    assign o_corner = r_corner;
endmodule

// File: rtl/bouncing_square_pattern.sv
// bouncing_square_pattern: two-stage pixel pipeline drawing a bouncing square over a background
module bouncing_square_pattern #(
    parameter int COORD_BITS  = video_pkg::COORD_BITS,
    parameter int COLOUR_BITS = video_pkg::COLOUR_BITS,
    parameter int H_RES       = video_pkg::H_RES,
    parameter int V_RES       = video_pkg::V_RES,
    parameter int SQ_SIZE     = 64,
    parameter int SPEED       = 2,
    parameter int X0          = 0,
    parameter int Y0          = 0
) (
    input  logic                   i_clk_pxl,
    input  logic                   i_reset,
    input  logic [COORD_BITS-1:0]  i_sx,
    input  logic [COORD_BITS-1:0]  i_sy,
    input  logic                   i_de,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_nf,
    input  logic                   i_pause,
    output logic [COLOUR_BITS-1:0] o_r,
    output logic [COLOUR_BITS-1:0] o_g,
    output logic [COLOUR_BITS-1:0] o_b,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic                   o_corner
);
    import video_pkg::*;
    localparam int W = COORD_BITS + 1;
    logic [COORD_BITS-1:0] w_pos_x, w_pos_y;
    logic [1:0]            w_idx;
    logic                  w_in_sq;
    rgb_t                  w_rgb;
    logic                  r_in_sq, r_de1, r_hs1, r_vs1;
    rgb_t                  r_rgb;
    logic                  r_de2, r_hs2, r_vs2;
    square_motion #(
        .COORD_BITS(COORD_BITS), .H_RES(H_RES), .V_RES(V_RES),
        .SQ_SIZE(SQ_SIZE), .SPEED(SPEED), .X0(X0), .Y0(Y0)
    ) u_motion (
        .i_clk_pxl(i_clk_pxl),
        .i_reset  (i_reset),
        .i_nf     (i_nf),
        .i_pause  (i_pause),
        .o_pos_x  (w_pos_x),
        .o_pos_y  (w_pos_y),
        .o_idx    (w_idx),
        .o_corner (o_corner)
    );
    always_comb begin
        w_in_sq = ({1'b0, w_pos_x} <= {1'b0, i_sx}) && ({1'b0, i_sx} < {1'b0, w_pos_x} + W'(SQ_SIZE))
               && ({1'b0, w_pos_y} <= {1'b0, i_sy}) && ({1'b0, i_sy} < {1'b0, w_pos_y} + W'(SQ_SIZE));
        w_rgb   = r_in_sq ? PALETTE[w_idx] : BG_COLOUR;
    end
    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            {r_in_sq, r_de1, r_hs1, r_vs1} <= '0;
            {r_de2, r_hs2, r_vs2}          <= '0;
            r_rgb                          <= '0;
        end else begin
            {r_in_sq, r_de1, r_hs1, r_vs1} <= {w_in_sq, i_de, i_hsync, i_vsync};
            {r_de2, r_hs2, r_vs2}          <= {r_de1, r_hs1, r_vs1};
            r_rgb                          <= r_de1 ? w_rgb : '0;
        end
    end
    assign o_r     = r_rgb.r;
    assign o_g     = r_rgb.g;
    assign o_b     = r_rgb.b;
    assign o_hsync = r_hs2;
    assign o_vsync = r_vs2;
    assign o_de    = r_de2;
endmodule

// File: tb/tb_bouncing_square_pattern.sv
// tb_bouncing_square_pattern: random-stimulus check of four differently placed squares against a frame-level model
module tb_bouncing_square_pattern;
    localparam int N  = 4;
    localparam int X0S [N] = '{0, 400, 160, 100};
    localparam int SQ = 64, SP = 2, HR = 640, VR = 480;
    localparam logic [23:0] PAL [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'hFFFF00};
    localparam logic [23:0] BG = 24'h00008B;
    localparam logic DN = video_pkg::DIR_NEG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst;
    logic [9:0]   sx, sy;
    logic         de, hs, vs, nf, pause, run;
    logic [27:0]  out [N];
    logic [27:0]  st  [N];
    int           n_tests = 0, n_fail = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [7:0] cr, cg, cb;
        logic       oh, ov, od, oc;
        bouncing_square_pattern #(.X0(X0S[g]), .Y0(0)) u_dut (
            .i_clk_pxl(clk), .i_reset(rst[g]), .i_sx(sx), .i_sy(sy), .i_de(de),
            .i_hsync(hs), .i_vsync(vs), .i_nf(nf), .i_pause(pause),
            .o_r(cr), .o_g(cg), .o_b(cb), .o_hsync(oh), .o_vsync(ov), .o_de(od), .o_corner(oc)
        );
        assign out[g] = {cr, cg, cb, oh, ov, od, oc};
        assign st[g]  = {4'd0, u_dut.u_motion.r_pos_x, u_dut.u_motion.r_pos_y,
                         u_dut.u_motion.r_dir_x, u_dut.u_motion.r_dir_y, u_dut.u_motion.r_idx};
    end

    int          px [N], py [N], dx [N], dy [N], pi [N];
    logic [27:0] prev [N], exp_out [N];

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] mk(input int x, input int y, input bit xn, input bit yn, input int idx);
        return {4'd0, 10'(x), 10'(y), xn ? DN : ~DN, yn ? DN : ~DN, 2'(idx)};
    endfunction

    function automatic logic [27:0] model_st(input int i);
        return mk(px[i], py[i], dx[i] < 0, dy[i] < 0, pi[i]);
    endfunction

    task automatic move(inout int p, inout int d, input int res, output bit b);
        b = 1'b0;
        if (d > 0) begin
            if (p + SQ + SP >= res) begin p = res - SQ; d = -1; b = 1'b1; end
            else p += SP;
        end else if (p <= SP) begin p = 0; d = 1; b = 1'b1; end
        else p -= SP;
    endtask

    // Frame-level model: output after an edge is the pixel record captured one edge earlier
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst[i]) begin
                exp_out[i] = '0;
                prev[i]    = '0;
                px[i] = X0S[i]; py[i] = 0; dx[i] = 1; dy[i] = 1; pi[i] = 0;
            end else begin
                bit bx, by, hit;
                hit = de && sx >= px[i] && sx < px[i] + SQ && sy >= py[i] && sy < py[i] + SQ;
                exp_out[i] = prev[i];
                prev[i] = {de ? (hit ? PAL[pi[i]] : BG) : 24'h0, hs, vs, de, 1'b0};
                bx = 1'b0;
                by = 1'b0;
                if (nf && !pause) begin
                    move(px[i], dx[i], HR, bx);
                    move(py[i], dy[i], VR, by);
                    if (bx || by) pi[i] = (pi[i] + 1) % 4;
                end
                exp_out[i][0] = bx && by;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("cyc_out%0d", i), out[i], exp_out[i]);
                check($sformatf("cyc_st%0d", i), st[i], model_st(i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pix();
        de = 1'($urandom);
        hs = 1'($urandom);
        vs = 1'($urandom);
        sx = 10'(px[0] + int'($urandom_range(0, 100)) - 20);
        sy = 10'(py[0] + int'($urandom_range(0, 100)) - 20);
    endtask

    task automatic nf_tick();
        nf = 1'b1;
        de = 1'b0;
        hs = 1'($urandom);
        vs = 1'($urandom);
        tick();
        nf = 1'b0;
    endtask

    task automatic frame_body();
        repeat (3) begin
            rand_pix();
            tick();
        end
    endtask

    logic [27:0] sp;

    initial begin
        rst = '1;
        {sx, sy} = '0;
        {de, hs, vs, nf, pause, run} = '0;
        repeat (2) tick();
        run = 1'b1;
        check("rst_out", out[0], 28'h0);
        check("rst_st", st[0], mk(0, 0, 0, 0, 0));
        rst = '0;
        sx = 10; sy = 10; de = 1'b1;
        tick();
        sx = 100; sy = 100;
        tick();
        check("pix_10", out[0], {24'hFFFFFF, 4'b0010});
        de = 1'b0;
        tick();
        check("pix_100", out[0], {24'h00008B, 4'b0010});
        for (int k = 0; k < 208; k++) begin
            if (k == 87)  check("edge_pre", st[1], mk(574, 174, 0, 0, 0));
            if (k == 100) check("rstnf_pre", st[3], mk(300, 200, 0, 0, 0));
            if (k == 207) check("corner_pre", st[2], mk(574, 414, 0, 0, 0));
            if (k == 100) rst[3] = 1'b1;
            nf_tick();
            rst[3] = 1'b0;
            if (k == 87) begin
                check("edge_post", st[1], mk(576, 176, 1, 0, 1));
                check("edge_corner", {27'd0, out[1][0]}, 28'd0);
            end
            if (k == 100) begin
                check("rstnf_st", st[3], mk(100, 0, 0, 0, 0));
                check("rstnf_out", out[3], 28'h0);
            end
            if (k == 207) begin
                check("corner_post", st[2], mk(576, 416, 1, 1, 1));
                check("corner_pulse", {27'd0, out[2][0]}, 28'd1);
            end
            rand_pix();
            tick();
            if (k == 207) check("corner_once", {27'd0, out[2][0]}, 28'd0);
            frame_body();
        end
        pause = 1'b1;
        sp = model_st(0);
        repeat (3) begin
            nf_tick();
            frame_body();
        end
        check("pause_hold", st[0], sp);
        pause = 1'b0;
        nf_tick();
        check("resume_moved", {27'd0, st[0] == sp}, 28'd0);
        check("resume_st", st[0], model_st(0));
        repeat (200) begin
            rand_pix();
            tick();
        end
        de = 1'b0;
        tick();
        tick();
        check("de0_rgb", out[0][27:4], 24'h0);
        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bouncing_square_pattern.md
BOUNCING_SQUARE_PATTERN -- requirements
Module: bouncing_square_pattern

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- COORD_BITS, 10, screen coordinate width.
- COLOUR_BITS, 8, per-channel colour width.
- H_RES, 640, active width.
- V_RES, 480, active height.
- SQ_SIZE, 64, square edge in pixels.
- SPEED, 2, pixels moved per axis per frame.
- X0, 0, reset X position.
- Y0, 0, reset Y position.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk_pxl, in, 1, the block's one clock (pixel clock).
- i_reset, in, 1, synchronous active-high reset.
- i_sx, in, COORD_BITS, current pixel X.
- i_sy, in, COORD_BITS, current pixel Y.
- i_de, in, 1, data enable (active pixel).
- i_hsync, in, 1, horizontal sync, passed through.
- i_vsync, in, 1, vertical sync, passed through.
- i_nf, in, 1, one-cycle new-frame pulse.
- i_pause, in, 1, freezes motion while high.
- o_r, out, COLOUR_BITS, red channel, to TMDS encoder.
- o_g, out, COLOUR_BITS, green channel, to TMDS encoder.
- o_b, out, COLOUR_BITS, blue channel, to TMDS encoder.
- o_hsync, out, 1, hsync delayed to match RGB.
- o_vsync, out, 1, vsync delayed to match RGB.
- o_de, out, 1, de delayed to match RGB.
- o_corner, out, 1, one-cycle pulse on a corner hit.

Function
REQ-003 Square position (pos_x, pos_y) and direction (dir_x, dir_y) SHALL update only in the cycle i_nf=1 and i_pause=0; values SHALL be held otherwise.
REQ-004 X axis, dir_x=+: if pos_x+SQ_SIZE+SPEED >= H_RES, set pos_x=H_RES-SQ_SIZE and dir_x=-; else pos_x+=SPEED.
REQ-005 X axis, dir_x=-: if pos_x <= SPEED, set pos_x=0 and dir_x=+; else pos_x-=SPEED.
REQ-006 The Y axis SHALL follow REQ-004/005 using V_RES.
REQ-007 Bounce arithmetic SHALL use COORD_BITS+1 bits with no wrap; pos SHALL always lie in [0, RES-SQ_SIZE].
REQ-008 Any bounce SHALL advance the 2-bit palette index by exactly 1 (mod 4), including a simultaneous X+Y bounce.
REQ-009 Simultaneous X+Y bounce SHALL additionally pulse o_corner for one cycle, the cycle after i_nf.
REQ-010 Pipeline stage 1 SHALL register in_sq = (pos_x <= i_sx < pos_x+SQ_SIZE) && (pos_y <= i_sy < pos_y+SQ_SIZE), plus de/hsync/vsync.
REQ-011 Pipeline stage 2 SHALL register RGB: in_sq gives PALETTE[index], else BG_COLOUR; o_de=0 forces RGB=0.
REQ-012 Total latency i_* -> o_* SHALL be exactly 2 cycles; the sync/de delays SHALL equal the RGB delay.
REQ-013 A position update in the same cycle as a stage-1 compare SHALL take effect from the following cycle; no partial-frame tearing, since i_nf falls in blanking.
REQ-014 i_nf while i_reset=1 SHALL be ignored.

Reset
REQ-015 i_reset=1 SHALL set pos_x=X0, pos_y=Y0, dir_x=+, dir_y=+, palette index 0.
REQ-016 i_reset=1 SHALL clear all pipeline registers, so o_r/o_g/o_b/o_hsync/o_vsync/o_de/o_corner=0 the following cycle.
REQ-017 Reset asserted mid-frame SHALL take effect at the next edge regardless of i_nf or i_pause.

Structure
REQ-018 Shared package video_pkg SHALL hold:
- COORD_BITS, COLOUR_BITS, H_RES, V_RES.
- typedef rgb_t (struct of three COLOUR_BITS fields).
- BG_COLOUR = {00,00,8B}.
- PALETTE[4] = {FFFFFF, FF0000, 00FF00, FFFF00}.
REQ-019 Motion/bounce logic (REQ-003..009) SHALL be one sub-module, square_motion. Pixel compare and pipeline SHALL stay in the parent.

Verification
REQ-020 The bench SHALL cover:
- Reset release with X0=Y0=0: pixel (10,10) with de=1 -> two cycles later RGB=FFFFFF, o_de=1. Pixel (100,100) -> RGB=00008B.
- Right-edge bounce: pos_x=574, dir_x=+, SPEED=2, i_nf -> pos_x=576, dir_x=-, palette index 0->1, o_corner=0.
- Corner: pos=(574,414), both +, i_nf -> pos=(576,416), both -, index +1 only, o_corner pulses once.
- i_pause=1 over 3 i_nf pulses -> position, direction and index unchanged. De-assert pause -> movement resumes next i_nf.
- Latency: random hsync/vsync/de sequence -> outputs equal inputs delayed exactly 2 cycles. de=0 -> RGB=0.
- Reset asserted the same cycle as i_nf with pos=(300,200) -> pos=(X0,Y0), outputs 0 the next cycle.
